// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//
// Contents:
//   MODE_HOLD..MODE_SER : 3-bit operation select codes driven on 'mode'
//   state_t             : serializer FSM states (ST_IDLE, ST_SHIFT)
//   dbg_t               : observation bundle (FSM state + bit counter) that
//                         the top level drives out on its 'dbg' port
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_SER  = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Wide enough for the counter of the largest legal WIDTH (32 -> 6 bits).
    localparam int DBG_CNT_W = 6;

    typedef struct packed {
        state_t               state;
        logic [DBG_CNT_W-1:0] cnt;
    } dbg_t;

endpackage

// File: rtl/shift_register_n_bit_counter.sv
// bit_counter: small up-counter used to count serializer shift edges.
//
// Ports:
//   clk     : clock, rising edge
//   reset_p : synchronous active-high reset, clears cnt
//   clr     : synchronous clear, wins over inc
//   inc     : advance by one; wraps from MAX back to 0
//   cnt     : current count, never above MAX
//   last    : high while cnt == MAX
module bit_counter #(
    parameter int MAX = 7,
    parameter int CW  = $clog2(MAX + 2)
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    assign last = (cnt == MAX_C);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            // Wrap on the final count so the value never exceeds MAX.
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_register_n.sv
// shift_register_n: WIDTH-bit universal shift register with hold, load,
// logical shifts, rotates, arithmetic shift right and a self-timed MSB-first
// serializer.
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_p : synchronous active-high reset, priority over everything
//   en      : clock enable; low freezes q, sout, FSM state and bit counter
//   mode    : operation select (MODE_* in shift_reg_pkg), ignored while busy
//   d       : parallel load data (LOAD and SER start)
//   sin     : serial input for SHL / SHR
//   q       : register contents
//   sout    : registered copy of the last bit shifted out
//   busy    : high while a serialize operation is in progress
//   done    : one-cycle pulse when a serialize operation finishes
//   dbg     : FSM state and bit counter, for observation only
//
// Handshake: a SER request is taken only on an enabled edge while busy is
// low (which includes the done cycle); requests while busy are dropped.
module shift_register_n
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output dbg_t             dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             start;
    logic             shifting;

    // Serializer start: only from IDLE on an enabled SER edge.
    assign start    = en && (state == ST_IDLE) && (mode == MODE_SER);
    assign shifting = en && (state == ST_SHIFT);

    bit_counter #(
        .MAX (WIDTH - 1),
        .CW  (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .reset_p (reset_p),
        .clr     (start),
        .inc     (shifting),
        .cnt     (cnt),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset_p) begin
            q     <= RESET_VALUE;
            sout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= ST_IDLE;
        end else begin
            // done drops on every edge, enabled or not, so it is one cycle wide.
            done <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        case (mode)
                            MODE_HOLD: ;
                            MODE_LOAD: q <= d;
                            MODE_SHL: begin
                                q    <= {q[WIDTH-2:0], sin};
                                sout <= q[WIDTH-1];
                            end
                            MODE_SHR: begin
                                q    <= {sin, q[WIDTH-1:1]};
                                sout <= q[0];
                            end
                            MODE_ROL: begin
                                q    <= {q[WIDTH-2:0], q[WIDTH-1]};
                                sout <= q[WIDTH-1];
                            end
                            MODE_ROR: begin
                                q    <= {q[0], q[WIDTH-1:1]};
                                sout <= q[0];
                            end
                            MODE_ASR: begin
                                q    <= {q[WIDTH-1], q[WIDTH-1:1]};
                                sout <= q[0];
                            end
                            MODE_SER: begin
                                q     <= d;
                                busy  <= 1'b1;
                                state <= ST_SHIFT;
                            end
                            default: ;
                        endcase
                    end
                    ST_SHIFT: begin
                        // MSB first; zeros fill from the bottom.
                        sout <= q[WIDTH-1];
                        q    <= {q[WIDTH-2:0], 1'b0};
                        if (cnt_last) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dbg = '{state: state, cnt: DBG_CNT_W'(cnt)};

endmodule
